// File: rtl/alu_issue_stage.sv
// Decode-and-issue stage: valid/ready in, two-entry skid buffer, valid/ready out to the ALU.
// Optional issue/stall statistics counters are enabled by defining ALU_ISSUE_STATS_EN.
module alu_issue_stage #(
    parameter int ERR_CNT_W = 8,
    parameter int STAT_W    = 16
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8:0]           in_inst,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [3:0]           out_op,
    output logic [2:0]           out_ra,
    output logic [1:0]           out_rb,
    output logic                 out_flag_wr,
    output logic                 err_sticky,
    output logic [ERR_CNT_W-1:0] err_cnt
`ifdef ALU_ISSUE_STATS_EN
    ,
    output logic [STAT_W-1:0]    stat_issued,
    output logic [STAT_W-1:0]    stat_stall
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0] op;
        logic [2:0] ra;
        logic [1:0] rb;
        logic       flag_wr;
    } entry_t;

    state_t                 state_reg;
    entry_t                 m_reg;
    entry_t                 s_reg;
    entry_t                 in_entry;
    logic                   err_sticky_reg;
    logic [ERR_CNT_W-1:0]   err_cnt_reg;

    logic                   accept;
    logic                   transfer;
    logic                   legal;
    logic                   take;

    // in_ready depends only on registered state, never on out_ready
    assign in_ready  = (state_reg != TWO);
    assign out_valid = (state_reg != EMPTY);

    assign accept   = in_valid & in_ready;
    assign transfer = out_valid & out_ready;
    assign legal    = (in_inst[8:5] <= 4'd10);
    assign take     = accept & legal;

    assign in_entry.op      = in_inst[8:5];
    assign in_entry.ra      = in_inst[4:2];
    assign in_entry.rb      = in_inst[1:0];
    assign in_entry.flag_wr = (in_inst[8:5] >= 4'd8);

    assign out_op      = m_reg.op;
    assign out_ra      = m_reg.ra;
    assign out_rb      = m_reg.rb;
    assign out_flag_wr = m_reg.flag_wr;
    assign err_sticky  = err_sticky_reg;
    assign err_cnt     = err_cnt_reg;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg      <= EMPTY;
            m_reg          <= '0;
            s_reg          <= '0;
            err_sticky_reg <= 1'b0;
            err_cnt_reg    <= '0;
        end else if (flush) begin
            // Flushed beats are dropped entirely, including illegal-opcode accounting
            state_reg <= EMPTY;
        end else begin
            if (accept && !legal) begin
                err_sticky_reg <= 1'b1;
                if (err_cnt_reg != {ERR_CNT_W{1'b1}})
                    err_cnt_reg <= err_cnt_reg + ERR_CNT_W'(1);
            end
            case (state_reg)
                EMPTY: begin
                    if (take) begin
                        m_reg     <= in_entry;
                        state_reg <= ONE;
                    end
                end
                ONE: begin
                    if (take && transfer) begin
                        m_reg <= in_entry;
                    end else if (take) begin
                        s_reg     <= in_entry;
                        state_reg <= TWO;
                    end else if (transfer) begin
                        state_reg <= EMPTY;
                    end
                end
                TWO: begin
                    if (transfer) begin
                        m_reg     <= s_reg;
                        state_reg <= ONE;
                    end
                end
                default: state_reg <= EMPTY;
            endcase
        end
    end

`ifdef ALU_ISSUE_STATS_EN
    logic [STAT_W-1:0] stat_issued_reg;
    logic [STAT_W-1:0] stat_stall_reg;

    assign stat_issued = stat_issued_reg;
    assign stat_stall  = stat_stall_reg;

    // Counters ignore flush and wrap naturally
    always_ff @(posedge Clk) begin
        if (Reset) begin
            stat_issued_reg <= '0;
            stat_stall_reg  <= '0;
        end else begin
            if (transfer)
                stat_issued_reg <= stat_issued_reg + STAT_W'(1);
            if (out_valid && !out_ready)
                stat_stall_reg <= stat_stall_reg + STAT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage; a second instance with ERR_CNT_W=2 checks saturation.
`timescale 1ns/1ps
module tb_alu_issue_stage;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       flush;
    logic       in_valid;
    logic [8:0] in_inst;
    logic       out_ready;

    logic       in_ready, out_valid, out_flag_wr, err_sticky;
    logic [3:0] out_op;
    logic [2:0] out_ra;
    logic [1:0] out_rb;
    logic [7:0] err_cnt;

    logic       in_ready2, out_valid2, out_flag_wr2, err_sticky2;
    logic [3:0] out_op2;
    logic [2:0] out_ra2;
    logic [1:0] out_rb2;
    logic [1:0] err_cnt2;

`ifdef ALU_ISSUE_STATS_EN
    logic [15:0] stat_issued, stat_stall, stat_issued2, stat_stall2;
`endif

    int tests = 0;
    int fails = 0;

    always #5 Clk = ~Clk;

    alu_issue_stage dut (
        .Clk(Clk), .Reset(Reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_ra(out_ra), .out_rb(out_rb), .out_flag_wr(out_flag_wr),
        .err_sticky(err_sticky), .err_cnt(err_cnt)
`ifdef ALU_ISSUE_STATS_EN
        , .stat_issued(stat_issued), .stat_stall(stat_stall)
`endif
    );

    alu_issue_stage #(.ERR_CNT_W(2)) dut2 (
        .Clk(Clk), .Reset(Reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready2), .in_inst(in_inst),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_op(out_op2), .out_ra(out_ra2), .out_rb(out_rb2), .out_flag_wr(out_flag_wr2),
        .err_sticky(err_sticky2), .err_cnt(err_cnt2)
`ifdef ALU_ISSUE_STATS_EN
        , .stat_issued(stat_issued2), .stat_stall(stat_stall2)
`endif
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        tests++;
        if (obs !== expv) begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [8:0] mk(input logic [3:0] op, input logic [2:0] ra, input logic [1:0] rb);
        return {op, ra, rb};
    endfunction

    initial begin
        Reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_inst = '0; out_ready = 1'b0;
        tick(); tick();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_op", out_op, 4'd0);
        chk("rst_out_ra", out_ra, 3'd0);
        chk("rst_out_rb", out_rb, 2'd0);
        chk("rst_flag_wr", out_flag_wr, 1'b0);
        chk("rst_err_sticky", err_sticky, 1'b0);
        chk("rst_err_cnt", err_cnt, 8'd0);
        $display("[TB] reset checked");
        Reset = 1'b0;

        out_ready = 1'b1; in_valid = 1'b1; in_inst = 9'b0001_011_10;
        tick();
        in_valid = 1'b0;
        chk("sub_valid", out_valid, 1'b1);
        chk("sub_op", out_op, 4'd1);
        chk("sub_ra", out_ra, 3'd3);
        chk("sub_rb", out_rb, 2'd2);
        chk("sub_flag", out_flag_wr, 1'b0);
        $display("[TB] SUB issued op=%0d ra=%0d rb=%0d", out_op, out_ra, out_rb);
        tick();
        chk("sub_drain", out_valid, 1'b0);

        in_valid = 1'b1; in_inst = mk(4'd0, 3'd1, 2'd1);
        chk("stream_rdy0", in_ready, 1'b1);
        tick();
        chk("add_valid", out_valid, 1'b1);
        chk("add_op", out_op, 4'd0);
        chk("add_flag", out_flag_wr, 1'b0);
        $display("[TB] stream op=%0d flag=%0d", out_op, out_flag_wr);
        in_inst = mk(4'd8, 3'd2, 2'd0);
        chk("stream_rdy1", in_ready, 1'b1);
        tick();
        chk("seq_valid", out_valid, 1'b1);
        chk("seq_op", out_op, 4'd8);
        chk("seq_ra", out_ra, 3'd2);
        chk("seq_flag", out_flag_wr, 1'b1);
        $display("[TB] stream op=%0d flag=%0d", out_op, out_flag_wr);
        in_inst = mk(4'd10, 3'd5, 2'd3);
        chk("stream_rdy2", in_ready, 1'b1);
        tick();
        chk("slt_valid", out_valid, 1'b1);
        chk("slt_op", out_op, 4'd10);
        chk("slt_rb", out_rb, 2'd3);
        chk("slt_flag", out_flag_wr, 1'b1);
        $display("[TB] stream op=%0d flag=%0d", out_op, out_flag_wr);
        in_valid = 1'b0;
        tick();
        chk("stream_drain", out_valid, 1'b0);

        out_ready = 1'b0; in_valid = 1'b1; in_inst = mk(4'd4, 3'd1, 2'd2);
        tick();
        chk("bp_first_op", out_op, 4'd4);
        chk("bp_rdy_one", in_ready, 1'b1);
        in_inst = mk(4'd3, 3'd6, 2'd1);
        tick();
        chk("bp_rdy_two", in_ready, 1'b0);
        chk("bp_hold_op", out_op, 4'd4);
        in_inst = mk(4'd2, 3'd7, 2'd3);
        tick();
        chk("bp_still_two", in_ready, 1'b0);
        chk("bp_hold_ra", out_ra, 3'd1);
        chk("bp_hold_valid", out_valid, 1'b1);
        out_ready = 1'b1;
        tick();
        chk("bp_iss2_op", out_op, 4'd3);
        chk("bp_iss2_ra", out_ra, 3'd6);
        chk("bp_rdy_back", in_ready, 1'b1);
        $display("[TB] backpressure issued op=%0d", out_op);
        tick();
        chk("bp_iss3_op", out_op, 4'd2);
        chk("bp_iss3_rb", out_rb, 2'd3);
        chk("bp_iss3_valid", out_valid, 1'b1);
        $display("[TB] backpressure issued op=%0d", out_op);
        in_valid = 1'b0;
        tick();
        chk("bp_drain", out_valid, 1'b0);

        in_valid = 1'b1; in_inst = mk(4'd12, 3'd0, 2'd0);
        tick();
        chk("ill12_valid", out_valid, 1'b0);
        chk("ill12_sticky", err_sticky, 1'b1);
        chk("ill12_cnt", err_cnt, 8'd1);
        in_inst = mk(4'd15, 3'd7, 2'd3);
        tick();
        chk("ill15_valid", out_valid, 1'b0);
        chk("ill15_cnt", err_cnt, 8'd2);
        chk("ill15_cnt2", err_cnt2, 2'd2);
        $display("[TB] illegal beats err_cnt=%0d", err_cnt);
        in_inst = mk(4'd11, 3'd0, 2'd0);
        tick();
        chk("ill_c3", err_cnt2, 2'd3);
        in_inst = mk(4'd13, 3'd0, 2'd0);
        tick();
        in_inst = mk(4'd14, 3'd0, 2'd0);
        tick();
        chk("ill_cnt5", err_cnt, 8'd5);
        chk("ill_sat2", err_cnt2, 2'd3);
        chk("ill_sat_sticky2", err_sticky2, 1'b1);
        chk("ill_none_issued", out_valid, 1'b0);
        $display("[TB] saturation err_cnt=%0d err_cnt2=%0d", err_cnt, err_cnt2);

        out_ready = 1'b0; in_inst = mk(4'd0, 3'd2, 2'd2);
        tick();
        in_inst = mk(4'd11, 3'd5, 2'd1);
        tick();
        chk("ill_one_valid", out_valid, 1'b1);
        chk("ill_one_op", out_op, 4'd0);
        chk("ill_one_ra", out_ra, 3'd2);
        chk("ill_one_rdy", in_ready, 1'b1);
        chk("ill_one_cnt", err_cnt, 8'd6);

        in_inst = mk(4'd1, 3'd1, 2'd1);
        tick();
        chk("fl_two", in_ready, 1'b0);
        flush = 1'b1; in_inst = mk(4'd2, 3'd4, 2'd0);
        tick();
        chk("fl_valid", out_valid, 1'b0);
        chk("fl_rdy", in_ready, 1'b1);
        $display("[TB] flush from TWO out_valid=%0d", out_valid);
        in_inst = mk(4'd13, 3'd0, 2'd0);
        tick();
        chk("fl_ill_cnt", err_cnt, 8'd6);
        in_inst = mk(4'd5, 3'd3, 2'd3);
        tick();
        chk("fl_legal_valid", out_valid, 1'b0);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk("fl_never_appears", out_valid, 1'b0);

        out_ready = 1'b0; in_valid = 1'b1; in_inst = mk(4'd6, 3'd4, 2'd1);
        tick();
        in_valid = 1'b0;
        chk("mid_loaded", out_valid, 1'b1);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        tick();
        chk("mid_valid", out_valid, 1'b0);
        chk("mid_sticky", err_sticky, 1'b0);
        chk("mid_cnt", err_cnt, 8'd0);
        chk("mid_op", out_op, 4'd0);
        $display("[TB] reset mid-op out_valid=%0d", out_valid);

`ifdef ALU_ISSUE_STATS_EN
        chk("st_rst_issued", stat_issued, 16'd0);
        chk("st_rst_stall", stat_stall, 16'd0);
        in_valid = 1'b1; in_inst = mk(4'd7, 3'd1, 2'd0);
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick(); tick();
        out_ready = 1'b1;
        tick();
        chk("st_stall", stat_stall, 16'd4);
        chk("st_issued", stat_issued, 16'd1);
        $display("[TB] stats issued=%0d stall=%0d", stat_issued, stat_stall);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Decode-and-issue stage between instruction fetch and the ALU.
- Accepts 9-bit instructions on a valid/ready handshake and decodes the 4-bit ALU operation and register selects.
- Issues decoded ops to the ALU/execute stage on a second valid/ready handshake.
- Two-entry skid buffer: full throughput, registered outputs, 1-cycle latency. Illegal opcodes are trapped, not issued.

Parameters:
- ERR_CNT_W, 8, width of saturating illegal-opcode counter
- STAT_W, 16, width of optional statistics counters (wraps)

Ports:
- Clk  in  1  clock, rising edge
- Reset  in  1  synchronous, active-high reset
- flush  in  1  discard all buffered ops this cycle
- in_valid  in  1  instruction beat valid
- in_ready  out  1  stage can accept a beat
- in_inst  in  9  instruction: [8:5] opcode, [4:2] ra, [1:0] rb
- out_valid  out  1  decoded op valid
- out_ready  in  1  ALU accepts op
- out_op  out  4  ALU op: ADD=0, SUB=1, AND=2, OR=3, XOR=4, LSH=5, RSH=6, BXOR=7, SEQ=8, SNE=9, SLT=10
- out_ra  out  3  source/dest register A
- out_rb  out  2  source register B
- out_flag_wr  out  1  1 for SEQ/SNE/SLT (result goes to flag register), else 0
- err_sticky  out  1  set on first illegal opcode, cleared only by Reset
- err_cnt  out  ERR_CNT_W  illegal opcodes seen, saturating

Behaviour:
- Clk is the only clock. Reset is synchronous, active-high. Both are fixed.
- Reset values:
  - state EMPTY
  - out_valid=0, in_ready=1
  - out_op=0, out_ra=0, out_rb=0, out_flag_wr=0
  - err_sticky=0, err_cnt=0
- Handshakes:
  - Input accept = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - out_* fields hold stable while out_valid=1 and out_ready=0.
- Buffer state machine (main register M drives out_*, skid register S):
  - EMPTY: accept -> ONE (M loaded); out_valid=0.
  - ONE: out_valid=1.
    - accept with no transfer -> TWO (S loaded).
    - accept with transfer -> ONE (M reloaded).
    - transfer only -> EMPTY.
  - TWO: in_ready=0, out_valid=1.
    - transfer -> ONE (M<=S).
- in_ready = (state != TWO). It is a function of registered state only, with no combinational path from out_ready.
- Latency: a legal op accepted in cycle N appears with out_valid=1 in cycle N+1.
- Ordering: strictly FIFO.
- Decode: opcode 0..10 is legal and maps 1:1 to out_op. out_flag_wr = (op>=8).
- Illegal opcodes (11..15):
  - The beat is accepted (handshake completes) but no entry is written and the state is unchanged.
  - err_sticky<=1.
  - err_cnt increments and saturates at 2^ERR_CNT_W-1.
- flush (priority below Reset, above all else):
  - Next state EMPTY.
  - Any beat accepted in the same cycle is discarded, including its illegal-opcode accounting.
  - A transfer completing in the flush cycle is still counted as issued by the ALU.
- Reset mid-operation: all buffered ops are lost and no spurious out_valid is produced after Reset deasserts.
- Simultaneous accept+transfer in ONE sustains 1 op/cycle indefinitely.

Optional Feature:
- Macro ALU_ISSUE_STATS_EN.
- When defined:
  - Adds outputs stat_issued (STAT_W): +1 per output transfer.
  - Adds stat_stall (STAT_W): +1 per cycle with out_valid=1 and out_ready=0.
  - Both reset to 0 on Reset, are unaffected by flush, and wrap at 2^STAT_W.
- When undefined: the ports and counters are absent, and all other behaviour is identical.

Test Plan:
- Reset, then in_inst=9'b0001_011_10 (SUB, ra=3, rb=2) with out_ready=1 -> next cycle out_valid=1, out_op=1, out_ra=3, out_rb=2, out_flag_wr=0.
- Stream ADD, SEQ, SLT back-to-back with out_ready=1 -> one op per cycle. Issued out_op=0, 8, 10 with out_flag_wr=0, 1, 1. in_ready stays 1.
- out_ready=0, push 3 legal ops -> first two are accepted and in_ready drops to 0 after the second. Raise out_ready -> ops issue in order, no loss or duplication.
- Inject opcode 12 then opcode 15 -> neither is issued, err_sticky=1, err_cnt=2. With ERR_CNT_W=2, 5 illegal beats give err_cnt=3.
- State TWO, assert flush for one cycle with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the flushed beat never appears.
- ALU_ISSUE_STATS_EN defined, hold out_ready=0 for 4 cycles with one op buffered, then release -> stat_stall=4, stat_issued=1.
